// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address validity and
// highest-index write-port arbitration.
package regfile_pkg;

  localparam int MaxPorts = 16;
  localparam int IdxW     = $clog2(MaxPorts);

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } winner_t;

  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned n_regs,
                                      input int unsigned zero_reg);
    return (addr < n_regs) && !((zero_reg != 0) && (addr == 0));
  endfunction

  // Later ports override earlier ones, so the last hit found is the winner.
  function automatic winner_t hi_winner(input logic [MaxPorts-1:0] hit);
    winner_t w;
    w = '0;
    for (int p = 0; p < MaxPorts; p++) begin
      if (hit[p]) begin
        w.found = 1'b1;
        w.idx   = IdxW'(p);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file: reads, writes,
// reservations and scoreboard status.
interface regfile_if #(
  parameter int DataWidth   = 32,
  parameter int NRegisters  = 32,
  parameter int NReadPorts  = 2,
  parameter int NWritePorts = 2
);
  localparam int AddrWidth  = $clog2(NRegisters);
  localparam int CountWidth = $clog2(NRegisters + 1);

  logic [NReadPorts-1:0][AddrWidth-1:0]  rd_addr;
  logic [NReadPorts-1:0][DataWidth-1:0]  rd_data;
  logic [NReadPorts-1:0]                 rd_pending;
  logic [NWritePorts-1:0]                we;
  logic [NWritePorts-1:0][AddrWidth-1:0] wr_addr;
  logic [NWritePorts-1:0][DataWidth-1:0] wr_data;
  logic                                  rsv_en;
  logic [AddrWidth-1:0]                  rsv_addr;
  logic [CountWidth-1:0]                 pending_count;
  logic                                  wr_collision;

  modport master (
    output rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_pending, pending_count, wr_collision
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_pending, pending_count, wr_collision
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reservation,
// cleared by writeback, with a registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NRegisters  = 32,
  parameter int NReadPorts  = 2,
  parameter int NWritePorts = 2,
  parameter int Bypass      = 1,
  parameter int ZeroReg     = 1,
  localparam int AddrWidth  = $clog2(NRegisters),
  localparam int CountWidth = $clog2(NRegisters + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NWritePorts-1:0]                we,
  input  logic [NWritePorts-1:0][AddrWidth-1:0] wr_addr,
  input  logic                                  rsv_en,
  input  logic [AddrWidth-1:0]                  rsv_addr,
  input  logic [NReadPorts-1:0][AddrWidth-1:0]  rd_addr,
  output logic [NReadPorts-1:0]                 rd_pending,
  output logic [CountWidth-1:0]                 pending_count
);

  logic [NRegisters-1:0]  pending;
  logic [NRegisters-1:0]  pending_nxt;
  logic [CountWidth-1:0]  count_nxt;
  logic [NWritePorts-1:0] wr_ok;
  logic                   rsv_ok;
  logic [NReadPorts-1:0]  rd_wr_hit;
  logic [NReadPorts-1:0]  rd_rsv_hit;

  always_comb begin
    for (int p = 0; p < NWritePorts; p++)
      wr_ok[p] = we[p] && addr_valid(32'(wr_addr[p]), NRegisters, ZeroReg);
    rsv_ok = rsv_en && addr_valid(32'(rsv_addr), NRegisters, ZeroReg);
  end

  // Clear first, then set: a new issue outranks the retiring producer.
  always_comb begin
    pending_nxt = pending;
    for (int r = 0; r < NRegisters; r++) begin
      for (int p = 0; p < NWritePorts; p++)
        if (wr_ok[p] && (wr_addr[p] == AddrWidth'(r))) pending_nxt[r] = 1'b0;
      if (rsv_ok && (rsv_addr == AddrWidth'(r))) pending_nxt[r] = 1'b1;
    end
    count_nxt = '0;
    for (int r = 0; r < NRegisters; r++)
      count_nxt = count_nxt + CountWidth'(pending_nxt[r]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pending_nxt;
      pending_count <= count_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NReadPorts; i++) begin
      rd_wr_hit[i] = 1'b0;
      for (int p = 0; p < NWritePorts; p++)
        if (wr_ok[p] && (wr_addr[p] == rd_addr[i])) rd_wr_hit[i] = 1'b1;
      rd_rsv_hit[i] = rsv_ok && (rsv_addr == rd_addr[i]);
      rd_pending[i] = 1'b0;
      if (!reset && addr_valid(32'(rd_addr[i]), NRegisters, ZeroReg))
        rd_pending[i] = pending[rd_addr[i]] &&
                        !((Bypass != 0) && rd_wr_hit[i] && !rd_rsv_hit[i]);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, write
// collision flag and integrated pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int NRegisters  = 32,
  parameter int NReadPorts  = 2,
  parameter int NWritePorts = 2,
  parameter int Bypass      = 1,
  parameter int ZeroReg     = 1
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  bus
);

  localparam int AddrWidth = $clog2(NRegisters);
  localparam int Lo        = (ZeroReg != 0) ? 1 : 0;

  logic [DataWidth-1:0]                 mem [Lo:NRegisters-1];
  logic [NWritePorts-1:0]               wr_ok;
  logic                                 collision;
  logic [NReadPorts-1:0][MaxPorts-1:0]  byp_hit;
  winner_t                              byp_w [NReadPorts];

  always_comb begin
    for (int p = 0; p < NWritePorts; p++)
      wr_ok[p] = bus.we[p] && addr_valid(32'(bus.wr_addr[p]), NRegisters, ZeroReg);
  end

  always_comb begin
    collision = 1'b0;
    for (int p = 0; p < NWritePorts; p++)
      for (int q = p + 1; q < NWritePorts; q++)
        if (wr_ok[p] && wr_ok[q] && (bus.wr_addr[p] == bus.wr_addr[q])) collision = 1'b1;
  end

  // Later ports overwrite earlier ones within the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = Lo; r < NRegisters; r++) mem[r] <= '0;
      bus.wr_collision <= 1'b0;
    end else begin
      for (int p = 0; p < NWritePorts; p++)
        if (wr_ok[p]) mem[bus.wr_addr[p]] <= bus.wr_data[p];
      bus.wr_collision <= collision;
    end
  end

  always_comb begin
    for (int i = 0; i < NReadPorts; i++) begin
      byp_hit[i] = '0;
      for (int p = 0; p < NWritePorts; p++)
        if (wr_ok[p] && (bus.wr_addr[p] == bus.rd_addr[i])) byp_hit[i][p] = 1'b1;
      byp_w[i] = hi_winner(byp_hit[i]);
      bus.rd_data[i] = '0;
      if (!reset && addr_valid(32'(bus.rd_addr[i]), NRegisters, ZeroReg)) begin
        bus.rd_data[i] = mem[bus.rd_addr[i]];
        if ((Bypass != 0) && byp_w[i].found)
          for (int p = 0; p < NWritePorts; p++)
            if (byp_w[i].idx == IdxW'(p)) bus.rd_data[i] = bus.wr_data[p];
      end
    end
  end

  regfile_scoreboard #(
    .NRegisters  (NRegisters),
    .NReadPorts  (NReadPorts),
    .NWritePorts (NWritePorts),
    .Bypass      (Bypass),
    .ZeroReg     (ZeroReg)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .we            (bus.we),
    .wr_addr       (bus.wr_addr),
    .rsv_en        (bus.rsv_en),
    .rsv_addr      (bus.rsv_addr),
    .rd_addr       (bus.rd_addr),
    .rd_pending    (bus.rd_pending),
    .pending_count (bus.pending_count)
  );

endmodule
